// File: rtl/ahb_lite_des_master.sv
// AHB-Lite single-transfer master that runs one Triple-DES job on the slave:
// writes three keys, the data block and control, polls status, reads result.
module ahb_lite_des_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] KEY1_OFF  = 32'h00,
    parameter logic [31:0] KEY2_OFF  = 32'h08,
    parameter logic [31:0] KEY3_OFF  = 32'h10,
    parameter logic [31:0] DATA_OFF  = 32'h18,
    parameter logic [31:0] CTRL_OFF  = 32'h20,
    parameter logic [31:0] STAT_OFF  = 32'h28,
    parameter logic [31:0] RSLT_OFF  = 32'h30,
    parameter int unsigned POLL_MAX  = 64
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic        encr_decr,
    input  logic [63:0] key1_in,
    input  logic [63:0] key2_in,
    input  logic [63:0] key3_in,
    input  logic [63:0] data_in,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic [1:0]  err,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [63:0] HWDATA,
    input  logic [63:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_FIN, S_ERR} state_t;
    typedef enum logic [2:0] {WK1, WK2, WK3, WDAT, WCTL, RSTAT, RRES} step_t;

    state_t      state_q, state_d;
    step_t       step_q, step_d;
    logic [7:0]  poll_q, poll_d;
    logic [1:0]  err_q, err_d;
    logic [63:0] result_q, result_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [63:0] hwdata_q, hwdata_d;
    logic        latch;

    // key1 is consumed in the very first address phase, so it goes straight
    // into the HWDATA register and needs no operand copy of its own.
    logic [63:0] key2_q, key3_q, data_q;
    logic        encr_q;

    function automatic logic [31:0] step_off(input step_t s);
        case (s)
            WK1:     return KEY1_OFF;
            WK2:     return KEY2_OFF;
            WK3:     return KEY3_OFF;
            WDAT:    return DATA_OFF;
            WCTL:    return CTRL_OFF;
            RSTAT:   return STAT_OFF;
            default: return RSLT_OFF;
        endcase
    endfunction

    // Next-state, step sequencing and address/data phase setup.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        poll_d   = poll_q;
        err_d    = err_q;
        result_d = result_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        latch    = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_ADDR;
                step_d  = WK1;
                poll_d  = '0;
                err_d   = 2'b00;
                latch   = 1'b1;
            end
            S_ADDR: state_d = S_DATA;
            S_DATA: begin
                // Any ERROR response aborts the job; the slave's second
                // response cycle is absorbed while we sit in S_ERR.
                if (HRESP) begin
                    err_d   = 2'b01;
                    state_d = S_ERR;
                end else if (HREADY) begin
                    case (step_q)
                        RSTAT: begin
                            if (HRDATA[0]) begin
                                step_d  = RRES;
                                state_d = S_ADDR;
                            end else if (poll_q + 8'd1 == 8'(POLL_MAX)) begin
                                poll_d  = poll_q + 8'd1;
                                err_d   = 2'b10;
                                state_d = S_ERR;
                            end else begin
                                poll_d  = poll_q + 8'd1;
                                state_d = S_ADDR;
                            end
                        end
                        RRES: begin
                            result_d = HRDATA;
                            state_d  = S_FIN;
                        end
                        default: begin
                            step_d  = step_t'(step_q + 3'd1);
                            state_d = S_ADDR;
                        end
                    endcase
                end
            end
            S_FIN, S_ERR: state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
        // Address, direction and write data are loaded once per transfer and
        // then held through the whole data phase, including wait states.
        if (state_d == S_ADDR) begin
            haddr_d  = BASE_ADDR + step_off(step_d);
            hwrite_d = (step_d != RSTAT) && (step_d != RRES);
            case (step_d)
                WK1:     hwdata_d = key1_in;
                WK2:     hwdata_d = key2_q;
                WK3:     hwdata_d = key3_q;
                WDAT:    hwdata_d = data_q;
                WCTL:    hwdata_d = {62'b0, encr_q, 1'b1};
                default: hwdata_d = '0;
            endcase
        end
    end

    // State, bus and status registers.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q  <= S_IDLE;
            step_q   <= WK1;
            poll_q   <= '0;
            err_q    <= 2'b00;
            result_q <= '0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            poll_q   <= poll_d;
            err_q    <= err_d;
            result_q <= result_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
        end
    end

    // Job operands captured when a job is accepted.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            key2_q <= '0;
            key3_q <= '0;
            data_q <= '0;
            encr_q <= 1'b0;
        end else if (latch) begin
            key2_q <= key2_in;
            key3_q <= key3_in;
            data_q <= data_in;
            encr_q <= encr_decr;
        end
    end

    assign busy      = (state_q == S_ADDR) || (state_q == S_DATA);
    assign done      = (state_q == S_FIN) || (state_q == S_ERR);
    assign result    = result_q;
    assign err       = err_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign HTRANS    = (state_q == S_ADDR) ? TR_NONSEQ : TR_IDLE;
    assign HSIZE     = 3'b011;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

endmodule
